// File: rtl/pipe_redirect_ctrl.sv
// Pipeline stall/flush/redirect controller: back-propagates per-stage stall
// requests and turns commit-stage exceptions or ERET into a flush plus a held PC redirect.
module pipe_redirect_ctrl #(
  parameter int              STAGES     = 6,
  parameter int              NUM_EXC    = 7,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'hBFC00380),
  parameter int              CNT_W      = 16,
  localparam int             EXC_W      = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [STAGES-1:0] stall_req,
  input  logic [NUM_EXC-1:0] i_except,
  input  logic              i_eret,
  input  logic [PC_W-1:0]   i_epc,
  input  logic              redirect_ready,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic              flush,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   new_pc,
  output logic [EXC_W-1:0]  exc_code,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  new_pc_q, new_pc_d;
  logic [EXC_W-1:0] exc_code_q, exc_code_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [STAGES-1:0] stall_chain;
  logic [STAGES-1:0] bubble_chain;
  logic [EXC_W-1:0]  exc_idx;
  logic              any_exc;

  // A request from stage i holds stage i and every older (lower-index) stage;
  // a bubble appears just downstream of the youngest held stage.
  always_comb begin
    logic acc;
    acc          = 1'b0;
    stall_chain  = '0;
    bubble_chain = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc            = acc | stall_req[i];
      stall_chain[i] = acc;
    end
    for (int i = 1; i < STAGES; i++) begin
      bubble_chain[i] = stall_chain[i-1] & ~stall_chain[i];
    end
  end

  // Lowest set index wins, so scan from the top and let lower bits overwrite.
  always_comb begin
    exc_idx = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (i_except[i]) exc_idx = EXC_W'(i);
    end
  end

  assign any_exc = |i_except;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d        = state_q;
    new_pc_d       = new_pc_q;
    exc_code_d     = exc_code_q;
    stall_cnt_d    = stall_cnt_q;
    stall          = '0;
    bubble         = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_exc) begin
          exc_code_d = exc_idx;
          new_pc_d   = EXC_VECTOR;
          state_d    = FLUSH;
        end else if (i_eret) begin
          new_pc_d = i_epc;
          state_d  = FLUSH;
        end else begin
          stall  = stall_chain;
          bubble = bubble_chain;
          if ((|stall_req) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        state_d        = redirect_ready ? IDLE : REDIRECT;
      end
      REDIRECT: begin
        // Events arriving here are stale and are deliberately dropped.
        redirect_valid = 1'b1;
        stall          = {STAGES{1'b1}};
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      new_pc_q    <= '0;
      exc_code_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      new_pc_q    <= new_pc_d;
      exc_code_q  <= exc_code_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign new_pc    = new_pc_q;
  assign exc_code  = exc_code_q;
  assign stall_cnt = stall_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule
